hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Generates the stall/flush/extend request vectors consumed by the pipeline bubble/control unit.
//  Sits directly upstream of it, beside the ID/EX/MEM stage logic.
//  Detects load-use hazards, taken-branch redirects, multi-cycle MDU ops in EX and data-memory waits in MEM.
//  Stage bit order for all 5-bit vectors: [4]=IF [3]=ID [2]=EX [1]=MEM [0]=WB.
// PARAMETERS
//  MDU_LAT  4  total cycles an MDU op occupies EX (legal range 2..16)
// PORTS
//  clk             in   1  clock
//  rst             in   1  asynchronous active-low reset
//  id_rs           in   5  ID source reg rs
//  id_rt           in   5  ID source reg rt
//  id_use_rs       in   1  ID instruction reads rs
//  id_use_rt       in   1  ID instruction reads rt
//  ex_valid        in   1  EX holds a real instruction (not a bubble)
//  ex_rd           in   5  EX destination reg
//  ex_mem_read     in   1  EX instruction is a load
//  ex_branch_taken in   1  EX resolved a taken branch/jump
//  ex_mdu_start    in   1  EX instruction is an MDU op
//  mem_req         in   1  MEM stage has a valid load/store access
//  mem_ready       in   1  data memory completes the access this cycle
//  stall           out  5  stall requests
//  flush           out  5  flush requests
//  extend          out  5  extend requests
//  mdu_busy        out  1  MDU FSM in BUSY
// BEHAVIOUR
//  Reset: MEM FSM=M_IDLE, MDU FSM=D_IDLE, cnt=0. All outputs forced 0 while rst low.
//  Unused bits tied 0: stall[4,2,0], flush[4,2:0], extend[4,3,1:0].
//  Outputs are combinational from FSM state and inputs (0-cycle latency).
//  mem_stall (=stall[1]):
//   - M_IDLE: mem_req & !mem_ready -> stall[1]=1, go M_WAIT.
//   - M_IDLE: mem_req & mem_ready -> no stall.
//   - M_WAIT: stall[1]=1 until mem_ready. On mem_ready: stall[1]=0, go M_IDLE.
//   - M_WAIT: mem_req dropping -> stall[1]=0, go M_IDLE.
//  load-use (stall[3]):
//   - Condition: ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
//   - Multiple stall bits may be set together; the consumer resolves priority.
//  branch (flush[3]):
//   - Asserted when ex_valid & ex_branch_taken & !mem_stall & !extend[2].
//   - Fires exactly once per branch, in the cycle EX advances.
//   - Deferred, not dropped, while EX is held.
//  MDU FSM (extend[2]), cnt 4 bits:
//   - D_IDLE: ex_valid & ex_mdu_start -> extend[2]=1, cnt<=MDU_LAT-2, go D_BUSY.
//   - D_BUSY, cnt!=0: extend[2]=1, cnt<=cnt-1. ex_mdu_start is ignored.
//   - D_BUSY, cnt==0 & !mem_stall: extend[2]=0, go D_IDLE. The op leaves EX at this edge.
//   - D_BUSY, cnt==0 & mem_stall: hold D_BUSY with extend[2]=0; EX is held by stall[1].
//   - Net effect: the op occupies EX for exactly MDU_LAT cycles with no memory stall.
//   - A back-to-back MDU op re-enters D_BUSY on the following cycle.
//  Reset mid-operation: both FSMs return to IDLE immediately; a pending branch flush is discarded.
// TESTING
//  1: load r5 in EX, ID reads rs=5 with use_rs=1 -> stall=5'b01000 for 1 cycle.
//     Repeat with ex_rd=0 -> stall=0.
//  2: taken branch in EX, no stalls -> flush=5'b01000 for exactly 1 cycle.
//  3: taken branch in EX while mem_req=1 and mem_ready low for 2 cycles -> flush=0 for those cycles.
//     Then flush[3]=1 in the mem_ready cycle and held 1 cycle.
//  4: MDU_LAT=4, ex_mdu_start pulse -> extend=5'b00100 for 3 cycles, then 0.
//     mdu_busy=1 for cycles 2..4.
//  5: mem_req=1, mem_ready low 3 cycles then 1 -> stall[1]=1 for 3 cycles, 0 on the ready cycle.
//     mem_req & mem_ready same cycle -> no stall.
//  6: assert rst low during D_BUSY (cnt=1) -> all outputs 0 and mdu_busy=0 asynchronously.
//     After release, outputs stay 0 with idle inputs.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: load-use, branch-redirect, MDU-extend and memory-wait request vectors
// for the downstream bubble/control unit; stage order [4]=IF [3]=ID [2]=EX [1]=MEM [0]=WB.
module hazard_unit #(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       ex_mdu_start,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic [4:0] stall,
  output logic [4:0] flush,
  output logic [4:0] extend,
  output logic       mdu_busy
);
  typedef enum logic {M_IDLE, M_WAIT} mem_state_e;
  typedef enum logic {D_IDLE, D_BUSY} mdu_state_e;
  mem_state_e mem_q, mem_d;
  mdu_state_e mdu_q, mdu_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_stall, load_use, mdu_ext, br_flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= M_IDLE;
      mdu_q <= D_IDLE;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      mdu_q <= mdu_d;
      cnt_q <= cnt_d;
    end
  end
  // A wait in either state ends on ready or on the request being withdrawn.
  always_comb begin
    mem_stall = mem_req & !mem_ready;
    mem_d     = mem_stall ? M_WAIT : M_IDLE;
  end
  always_comb begin
    mdu_d   = mdu_q;
    cnt_d   = cnt_q;
    mdu_ext = 1'b0;
    if (mdu_q == D_IDLE) begin
      if (ex_valid & ex_mdu_start) begin
        mdu_ext = 1'b1;
        cnt_d   = 4'(MDU_LAT - 2);
        mdu_d   = D_BUSY;
      end
    end else if (cnt_q != 4'd0) begin
      mdu_ext = 1'b1;
      cnt_d   = cnt_q - 4'd1;
    end else if (!mem_stall) begin
      mdu_d = D_IDLE;
    end
  end
  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
               ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    br_flush = ex_valid & ex_branch_taken & !mem_stall & !mdu_ext;
    stall    = rst ? {1'b0, load_use, 1'b0, mem_stall, 1'b0} : 5'd0;
    flush    = rst ? {1'b0, br_flush, 3'b000} : 5'd0;
    extend   = rst ? {2'b00, mdu_ext, 2'b00} : 5'd0;
    mdu_busy = rst & (mdu_q == D_BUSY);
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard_unit with MDU_LAT=4.
module tb_hazard_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_valid, ex_mem_read, ex_branch_taken, ex_mdu_start;
  logic       mem_req, mem_ready;
  logic [4:0] stall, flush, extend;
  logic       mdu_busy;
  int         n_tests = 0;
  int         n_fail = 0;

  hazard_unit #(.MDU_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .mem_req(mem_req),
    .mem_ready(mem_ready), .stall(stall), .flush(flush), .extend(extend), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] s, input logic [4:0] f,
                         input logic [4:0] e, input logic b);
    chk({tag, ".stall"}, stall, s);
    chk({tag, ".flush"}, flush, f);
    chk({tag, ".extend"}, extend, e);
    chk({tag, ".busy"}, {4'd0, mdu_busy}, {4'd0, b});
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    ex_mdu_start = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    mem_req = 1'b1; ex_valid = 1'b1; ex_branch_taken = 1'b1; ex_mdu_start = 1'b1;
    sample(); chk_all("reset", 5'd0, 5'd0, 5'd0, 1'b0);
    next(); rst = 1'b1; idle();
    sample(); chk_all("post_reset", 5'd0, 5'd0, 5'd0, 1'b0);

    next(); ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    sample(); chk_all("lu_rs", 5'b01000, 5'd0, 5'd0, 1'b0);
    next(); ex_rd = 5'd0; id_rs = 5'd0;
    sample(); chk("lu_r0", stall, 5'd0);
    next(); ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_use_rt = 1'b0;
    sample(); chk("lu_rt_unused", stall, 5'd0);
    next(); id_use_rt = 1'b1;
    sample(); chk("lu_rt", stall, 5'b01000);
    next(); ex_mem_read = 1'b0;
    sample(); chk("lu_not_load", stall, 5'd0);

    next(); idle(); ex_valid = 1'b1; ex_branch_taken = 1'b1;
    sample(); chk_all("br", 5'd0, 5'b01000, 5'd0, 1'b0);
    next(); idle();
    sample(); chk("br_once", flush, 5'd0);
    next(); ex_branch_taken = 1'b1;
    sample(); chk("br_bubble", flush, 5'd0);

    next(); idle(); ex_valid = 1'b1; ex_branch_taken = 1'b1; mem_req = 1'b1;
    sample(); chk_all("br_mw1", 5'b00010, 5'd0, 5'd0, 1'b0);
    next();
    sample(); chk_all("br_mw2", 5'b00010, 5'd0, 5'd0, 1'b0);
    next(); mem_ready = 1'b1;
    sample(); chk_all("br_mrdy", 5'd0, 5'b01000, 5'd0, 1'b0);
    next(); idle();
    sample(); chk("br_after", flush, 5'd0);

    next(); ex_valid = 1'b1; ex_mdu_start = 1'b1;
    sample(); chk_all("mdu_c1", 5'd0, 5'd0, 5'b00100, 1'b0);
    next(); ex_mdu_start = 1'b0; ex_branch_taken = 1'b1;
    sample(); chk_all("mdu_c2", 5'd0, 5'd0, 5'b00100, 1'b1);
    next(); ex_branch_taken = 1'b0;
    sample(); chk_all("mdu_c3", 5'd0, 5'd0, 5'b00100, 1'b1);
    next();
    sample(); chk_all("mdu_c4", 5'd0, 5'd0, 5'd0, 1'b1);
    next(); idle();
    sample(); chk_all("mdu_c5", 5'd0, 5'd0, 5'd0, 1'b0);

    next(); ex_valid = 1'b1; ex_mdu_start = 1'b1;
    sample(); chk("mdh_c1", extend, 5'b00100);
    next(); ex_mdu_start = 1'b0;
    next();
    sample(); chk("mdh_c3", extend, 5'b00100);
    next(); mem_req = 1'b1;
    sample(); chk_all("mdh_hold", 5'b00010, 5'd0, 5'd0, 1'b1);
    next(); mem_ready = 1'b1;
    sample(); chk_all("mdh_rdy", 5'd0, 5'd0, 5'd0, 1'b1);
    next(); idle();
    sample(); chk("mdh_idle", {4'd0, mdu_busy}, 5'd0);

    next(); mem_req = 1'b1;
    sample(); chk("mw1", stall, 5'b00010);
    next();
    sample(); chk("mw2", stall, 5'b00010);
    next();
    sample(); chk("mw3", stall, 5'b00010);
    next(); mem_ready = 1'b1;
    sample(); chk("mw_rdy", stall, 5'd0);
    next(); idle();
    next(); mem_req = 1'b1; mem_ready = 1'b1;
    sample(); chk("mem_fast", stall, 5'd0);
    next(); mem_ready = 1'b0;
    sample(); chk("mw_drop_a", stall, 5'b00010);
    next(); mem_req = 1'b0;
    sample(); chk("mw_drop", stall, 5'd0);

    next(); idle(); ex_valid = 1'b1; ex_mdu_start = 1'b1;
    next(); ex_mdu_start = 1'b0;
    next(); ex_branch_taken = 1'b1; mem_req = 1'b1;
    sample(); chk("rst_pre", extend, 5'b00100);
    #1 rst = 1'b0;
    #1 chk_all("rst_async", 5'd0, 5'd0, 5'd0, 1'b0);
    next(); idle(); rst = 1'b1;
    sample(); chk_all("rst_rel1", 5'd0, 5'd0, 5'd0, 1'b0);
    next();
    sample(); chk_all("rst_rel2", 5'd0, 5'd0, 5'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
